// File: rtl/mac_result_drain.sv
// mac_result_drain: drains the finished C matrix of a MAC array as a
// requantized valid/ready stream, one element per cycle when not stalled.
//
// Handshake: an element transfers on a rising edge where m_valid && m_ready.
// While m_valid is high and m_ready is low, m_data/m_idx/m_last hold steady.
// m_valid never drops without a transfer, except when reset is asserted.
module mac_result_drain #(
  parameter int N       = 4,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5,
  localparam int IDX_W  = $clog2(N*N),
  localparam int CNT_W  = $clog2(N*N+1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    done_in,
  output logic [IDX_W-1:0]        out_addr,
  input  logic signed [ACC_W-1:0] out_rdata,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    rnd_en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic [IDX_W-1:0]        m_idx,
  output logic                    m_last,
  output logic                    busy,
  output logic                    drain_done,
  output logic [CNT_W-1:0]        sat_count,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2} state_t;

  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(N*N-1);
  localparam logic [CNT_W-1:0]   SAT_MAX = CNT_W'(N*N);
  localparam logic signed [ACC_W:0] ONE  = 1;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] MINV = -(ACC_W+1)'(2**(OUT_W-1));

  state_t state, state_next;
  logic [IDX_W-1:0]   rd_ptr;
  logic [SHIFT_W-1:0] shift_q;
  logic               rnd_q;

  logic start, load, finish;

  // requantization datapath on the element currently addressed
  logic signed [ACC_W:0]   s_ext, s_rnd, s_sh;
  logic signed [OUT_W-1:0] q_data;
  logic                    q_clip;

  assign out_addr  = rd_ptr;
  assign m_valid   = (state == SEND);
  assign m_last    = m_valid && (m_idx == LAST);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state and control strobes
  always_comb begin
    state_next = state;
    start      = 1'b0;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (done_in) begin
          start      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        load       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (m_ready) begin
          if (m_idx == LAST) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // sign-extend, optional round-half-up, arithmetic shift, saturate
  always_comb begin
    s_ext = {out_rdata[ACC_W-1], out_rdata};
    s_rnd = s_ext;
    if (rnd_q && (shift_q != '0))
      s_rnd = s_ext + (ONE << (shift_q - SHIFT_W'(1)));
    s_sh   = s_rnd >>> shift_q;
    q_clip = 1'b0;
    q_data = s_sh[OUT_W-1:0];
    if (s_sh > MAXV) begin
      q_data = MAXV[OUT_W-1:0];
      q_clip = 1'b1;
    end else if (s_sh < MINV) begin
      q_data = MINV[OUT_W-1:0];
      q_clip = 1'b1;
    end
  end

  // read pointer, output register, latched controls and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      shift_q    <= '0;
      rnd_q      <= 1'b0;
      m_data     <= '0;
      m_idx      <= '0;
      drain_done <= 1'b0;
      sat_count  <= '0;
    end else begin
      drain_done <= finish;
      if (start) begin
        shift_q   <= shift;
        rnd_q     <= rnd_en;
        sat_count <= '0;
        rd_ptr    <= '0;
      end
      if (load) begin
        m_data <= q_data;
        m_idx  <= rd_ptr;
        // pointer parks on the last element rather than wrapping
        if (rd_ptr != LAST) rd_ptr <= rd_ptr + IDX_W'(1);
        if (q_clip && (sat_count != SAT_MAX)) sat_count <= sat_count + CNT_W'(1);
      end
      if (finish) rd_ptr <= '0;
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: scoreboard bench for mac_result_drain.
module tb_mac_result_drain;

  logic               clock = 1'b0;
  logic               reset, done_in, rnd_en, m_ready;
  logic [4:0]         shift;
  logic [3:0]         out_addr, m_idx;
  logic signed [31:0] out_rdata;
  logic               m_valid, m_last, busy, drain_done;
  logic signed [7:0]  m_data;
  logic [4:0]         sat_count;
  logic [1:0]         state_dbg;

  logic signed [31:0] c_mem [16];
  logic [11:0]        exp_q [$];
  int                 n_checks = 0;
  int                 n_fail   = 0;
  int                 pop_cnt  = 0;
  bit                 stalled  = 1'b0;
  logic [12:0]        stall_snap;

  mac_result_drain dut (
    .clock(clock), .reset(reset), .done_in(done_in), .out_addr(out_addr),
    .out_rdata(out_rdata), .shift(shift), .rnd_en(rnd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .drain_done(drain_done), .sat_count(sat_count),
    .state_dbg(state_dbg)
  );

  // clock and combinational C memory
  always #5 clock = ~clock;
  assign out_rdata = c_mem[out_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference requantizer: returns {clip, data}
  function automatic logic [8:0] requant(input logic signed [31:0] v, input int sh, input bit rnd);
    longint s;
    s = longint'(v);
    if (rnd && sh > 0) s = s + (longint'(1) << (sh - 1));
    s = s >>> sh;
    if (s > 127)  return {1'b1, 8'sd127};
    if (s < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(s)};
  endfunction

  // monitor: pop on handshake, check stall stability
  always @(negedge clock) begin
    logic [11:0] e;
    if (stalled) begin
      check_eq("stall_valid", m_valid, 1);
      check_eq("stall_hold", {m_last, m_idx, m_data}, stall_snap);
    end
    stalled = 1'b0;
    if (!reset && m_valid) begin
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          pop_cnt++;
          check_eq("beat", {m_idx, m_data}, e);
          check_eq("m_last", m_last, e[11:8] == 4'd15);
        end
      end else begin
        stalled    = 1'b1;
        stall_snap = {m_last, m_idx, m_data};
      end
    end
  end

  task automatic push_model(input int sh, input bit rnd, output int nsat);
    logic [8:0] r;
    nsat = 0;
    for (int k = 0; k < 16; k++) begin
      r = requant(c_mem[k], sh, rnd);
      exp_q.push_back({4'(k), r[7:0]});
      nsat += int'(r[8]);
    end
    if (nsat > 16) nsat = 16;
  endtask

  task automatic push_const(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    exp_q.push_back({4'd0, d0});
    exp_q.push_back({4'd1, d1});
    exp_q.push_back({4'd2, d2});
    for (int k = 3; k < 16; k++) exp_q.push_back({4'(k), 8'd0});
  endtask

  // called at posedge+1; returns at posedge+1 with first element valid
  task automatic start_drain(input logic [4:0] sh, input bit rnd);
    pop_cnt = 0;
    done_in = 1'b1;
    shift   = sh;
    rnd_en  = rnd;
    @(posedge clock); #1;
    done_in = 1'b0;
    shift   = 5'($urandom);
    rnd_en  = 1'($urandom);
    check_eq("accept_busy", busy, 1);
    check_eq("accept_valid", m_valid, 0);
    @(posedge clock); #1;
    check_eq("first_valid", m_valid, 1);
    check_eq("first_idx", m_idx, 0);
  endtask

  task automatic run_to_done(input bit bp, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (bp) m_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      cycles++;
      if (drain_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("drain_done_seen", seen, 1);
    m_ready = 1'b1;
  endtask

  task automatic finish_drain(input int exp_sat);
    check_eq("end_busy", busy, 0);
    check_eq("end_valid", m_valid, 0);
    check_eq("end_addr", out_addr, 0);
    check_eq("sat_count", sat_count, exp_sat);
    check_eq("beats", pop_cnt, 16);
    check_eq("sb_empty", exp_q.size(), 0);
    @(posedge clock); #1;
    check_eq("done_pulse", drain_done, 0);
    check_eq("sat_hold", sat_count, exp_sat);
  endtask

  task automatic wait_idx(input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid && m_idx == target) begin
        found = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    check_eq("wait_idx", found, 1);
  endtask

  initial begin
    int nsat, cyc;
    reset = 1'b1; done_in = 1'b0; m_ready = 1'b0; shift = '0; rnd_en = 1'b0;
    for (int k = 0; k < 16; k++) c_mem[k] = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_data", m_data, 0);
    check_eq("rst_idx", m_idx, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_addr", out_addr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", drain_done, 0);
    check_eq("rst_sat", sat_count, 0);

    // latency and throughput: C[k]=k, shift 0
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) c_mem[k] = k;
    for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), 8'(k)});
    start_drain(5'd0, 1'b0);
    run_to_done(1'b0, cyc);
    check_eq("throughput_cycles", cyc, 16);
    finish_drain(0);

    // rounding, both modes
    for (int k = 0; k < 16; k++) c_mem[k] = 0;
    c_mem[0] = 384; c_mem[1] = -384; c_mem[2] = 383;
    push_const(8'd2, 8'hFF, 8'd1);
    start_drain(5'd8, 1'b1);
    run_to_done(1'b0, cyc);
    finish_drain(0);
    push_const(8'd1, 8'hFE, 8'd1);
    start_drain(5'd8, 1'b0);
    run_to_done(1'b0, cyc);
    finish_drain(0);

    // saturation
    c_mem[0] = 200000; c_mem[1] = -200000; c_mem[2] = 0;
    push_const(8'd127, 8'h80, 8'd0);
    start_drain(5'd4, 1'b0);
    run_to_done(1'b0, cyc);
    finish_drain(2);

    // random data, random shift/rounding, random backpressure
    for (int it = 0; it < 4; it++) begin
      int sh;
      bit rnd;
      sh  = $urandom_range(0, 31);
      rnd = 1'($urandom);
      for (int k = 0; k < 16; k++)
        c_mem[k] = ($urandom_range(0, 1) == 1) ? $signed($urandom)
                                                : $signed($urandom_range(0, 131071)) - 65536;
      push_model(sh, rnd, nsat);
      m_ready = 1'($urandom_range(0, 1));
      start_drain(5'(sh), rnd);
      run_to_done(1'b1, cyc);
      finish_drain(nsat);
    end

    // done_in ignored mid-drain, then reset mid-drain
    for (int k = 0; k < 16; k++) c_mem[k] = 7 * k - 50;
    push_model(0, 1'b0, nsat);
    m_ready = 1'b1;
    start_drain(5'd0, 1'b0);
    wait_idx(4'd5);
    done_in = 1'b1;
    @(posedge clock); #1;
    done_in = 1'b0;
    check_eq("no_restart", m_idx, 6);
    wait_idx(4'd9);
    reset = 1'b1; m_ready = 1'b0; done_in = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; done_in = 1'b0;
    check_eq("mid_rst_valid", m_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_addr", out_addr, 0);
    check_eq("mid_rst_idx", m_idx, 0);
    check_eq("mid_rst_sat", sat_count, 0);
    check_eq("unsent", exp_q.size(), 7);
    exp_q.delete();
    @(posedge clock); #1;
    check_eq("rst_done_discarded", busy, 0);
    check_eq("no_resume", m_valid, 0);
    m_ready = 1'b1;
    push_model(0, 1'b0, nsat);
    start_drain(5'd0, 1'b0);
    run_to_done(1'b0, cyc);
    check_eq("restart_cycles", cyc, 16);
    finish_drain(nsat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 Parameter N, default 4, matrix dimension; element count is N*N = 16.
REQ-002 Parameter ACC_W, default 32, accumulator (input element) width.
REQ-003 Parameter OUT_W, default 8, requantized output width, signed.
REQ-004 Parameter SHIFT_W, default 5, width of the shift control.
REQ-005 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 done_in  input  1  one-cycle pulse from the MAC array: C matrix is final.
REQ-008 out_addr  output  4  linear C read address (i*N+j) to the MAC array.
REQ-009 out_rdata  input  ACC_W signed  C element at out_addr, combinational, same cycle.
REQ-010 shift  input  SHIFT_W  right-shift amount, 0..31, sampled on the accepted done_in.
REQ-011 rnd_en  input  1  round-half-up enable, sampled with shift.
REQ-012 m_valid  output  1  output stream element valid.
REQ-013 m_ready  input  1  downstream ready.
REQ-014 m_data  output  OUT_W signed  requantized element.
REQ-015 m_idx  output  4  linear index of the element on m_data.
REQ-016 m_last  output  1  high with m_valid when m_idx = 15.
REQ-017 busy  output  1  high from the cycle after an accepted done_in until the last handshake.
REQ-018 drain_done  output  1  one-cycle pulse the cycle after the final handshake.
REQ-019 sat_count  output  5  number of saturated elements in the current or last drain.

Function
REQ-020 States SHALL be IDLE, FETCH, and SEND.
REQ-021 In IDLE, done_in=1 SHALL latch shift and rnd_en, clear sat_count, set rd_ptr=0, and go to FETCH.
REQ-022 done_in SHALL be ignored in FETCH and SEND.
REQ-023 out_addr SHALL equal the registered rd_ptr at all times, and SHALL be 0 in IDLE.
REQ-024 In FETCH, the block SHALL load the output register from out_rdata, set m_idx=rd_ptr, increment rd_ptr, assert m_valid, and go to SEND.
REQ-025 First-element latency SHALL be: done_in at edge T, m_valid high after edge T+2.
REQ-026 In SEND, m_valid SHALL stay high, and m_data, m_idx, and m_last SHALL stay stable while m_ready=0.
REQ-027 On a handshake in SEND with m_idx<15, the block SHALL load the element at rd_ptr in that same edge and increment rd_ptr.
REQ-028 With m_ready held high, the block SHALL sustain 1 element/cycle with no bubbles.
REQ-029 On a handshake with m_idx=15, the block SHALL drop m_valid, pulse drain_done, and return to IDLE.
REQ-030 rd_ptr SHALL NOT wrap past 15 during a drain; out_addr SHALL hold 15 until the return to IDLE.
REQ-031 Requantization step 1: form s = out_rdata sign-extended to ACC_W+1 bits.
REQ-032 Requantization step 2: if rnd_en=1 and shift>0, add 2^(shift-1) to s.
REQ-033 Requantization step 3: arithmetically right-shift s by the latched shift.
REQ-034 Requantization step 4: saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-128, 127].
REQ-035 shift=0 SHALL pass the value through unshifted, with saturation only.
REQ-036 sat_count SHALL increment once per element clipped at load, and SHALL saturate at 16.
REQ-037 sat_count SHALL hold its value after the drain until the next accepted done_in.
REQ-038 The upstream array is required to keep C stable while busy=1; this block SHALL NOT buffer C.

Reset
REQ-039 reset=1 SHALL force IDLE on the next edge, regardless of state, including mid-drain.
REQ-040 Reset values SHALL be: m_valid=0, m_data=0, m_idx=0, m_last=0, out_addr=0, busy=0, drain_done=0, sat_count=0; latched shift and rnd_en SHALL also be 0.
REQ-041 A done_in coincident with reset SHALL be discarded.
REQ-042 No partial stream SHALL resume after reset.

Verification
REQ-043 Latency and throughput: C[k]=k, shift=0, m_ready=1, done_in pulse -> m_valid at T+2; m_data=0..15 on 16 consecutive cycles; m_last only on idx 15; drain_done at the cycle after; sat_count=0.
REQ-044 Rounding: C[0]=384, C[1]=-384, C[2]=383, shift=8, rnd_en=1 -> m_data 2, -1, 1; with rnd_en=0 -> 1, -2, 1.
REQ-045 Saturation: C[0]=200000, C[1]=-200000, others 0, shift=4 -> m_data 127, -128, then 0s; sat_count=2.
REQ-046 Backpressure: m_ready toggles 1,0,0,1 pseudo-randomly -> each element appears exactly once, in order; outputs stable while stalled; no index skipped or repeated.
REQ-047 Ignore and reset: done_in re-pulsed at idx 5 -> no restart; reset asserted at idx 9 -> next cycle m_valid=0 and busy=0; a new done_in then restarts from idx 0.
